ysyx_22040237_mem_arb: RTL and testbench

- Arbitrates a single 64-bit memory port between the instruction fetch unit (IFU) and the load/store path driven by the execute stage's ls_info_bus.
- Sequences one outstanding transaction at a time through a small FSM.
- Formats store data and byte masks, and aligns and sign/zero-extends load data.
- Sits between IFU/EXU and the memory (DPI or bus) interface.

---
 rtl/ysyx_22040237_mem_arb.sv | 122 ++++++++++++
 tb/tb_ysyx_22040237_mem_arb.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040237_mem_arb.sv
// ysyx_22040237_mem_arb: single-port memory arbiter for IFU and LSU, one outstanding transaction
module ysyx_22040237_mem_arb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid_i,
    output logic              ifu_req_ready_o,
    input  logic [ADDR_W-1:0] ifu_addr_i,
    output logic              ifu_resp_valid_o,
    output logic [31:0]       ifu_inst_o,
    input  logic              lsu_req_valid_i,
    output logic              lsu_req_ready_o,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [6:0]        lsu_info_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic              lsu_resp_valid_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wen_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [7:0]        mem_wmask_o,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_misalign_o
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [6:0]        r_info;
    logic [DATA_W-1:0] r_wdata, r_rdata, w_rsh, w_ext;
    logic [1:0]        r_owner;
    logic [31:0]       r_inst;
    logic              r_ifu_resp, r_lsu_resp, r_err;
    logic              w_idle, w_lsu_acc, w_ifu_acc, w_acc, w_lsu_bad, w_ifu_bad, w_bad, w_done, w_us;
    logic [2:0]        w_sh;
    // a rejected request blocks arbitration for the cycle its error response is out
    assign w_idle          = (r_state == IDLE) && !r_err;
    assign lsu_req_ready_o = w_idle && lsu_req_valid_i;
    assign ifu_req_ready_o = w_idle && ifu_req_valid_i && !lsu_req_valid_i;
    assign w_lsu_acc       = lsu_req_ready_o;
    assign w_ifu_acc       = ifu_req_ready_o;
    assign w_acc           = w_lsu_acc || w_ifu_acc;
    assign w_lsu_bad = !$onehot(lsu_info_i[6:3]) || !(lsu_info_i[1] ^ lsu_info_i[0])
                     || (lsu_info_i[4] && lsu_addr_i[0])
                     || (lsu_info_i[5] && |lsu_addr_i[1:0])
                     || (lsu_info_i[6] && |lsu_addr_i[2:0]);
    assign w_ifu_bad = |ifu_addr_i[1:0];
    assign w_bad     = w_lsu_acc ? w_lsu_bad : w_ifu_bad;
    assign w_done    = (r_state == RESP) && mem_rvalid_i;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && w_acc && !w_bad) w_next = REQ;
        else if (r_state == REQ && mem_req_ready_i) w_next = RESP;
        else if (w_done) w_next = IDLE;
    end
    assign w_sh  = r_addr[2:0];
    assign w_us  = r_info[2];
    assign w_rsh = mem_rdata_i >> {w_sh, 3'b000};
    assign w_ext = r_info[6] ? w_rsh
                 : r_info[5] ? {{(DATA_W-32){!w_us && w_rsh[31]}}, w_rsh[31:0]}
                 : r_info[4] ? {{(DATA_W-16){!w_us && w_rsh[15]}}, w_rsh[15:0]}
                 :             {{(DATA_W-8){!w_us && w_rsh[7]}}, w_rsh[7:0]};
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_info     <= '0;
            r_wdata    <= '0;
            r_owner    <= '0;
            r_rdata    <= '0;
            r_inst     <= '0;
            r_ifu_resp <= 1'b0;
            r_lsu_resp <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ifu_resp <= 1'b0;
            r_lsu_resp <= 1'b0;
            r_err      <= 1'b0;
            if (w_acc) begin
                r_addr  <= w_lsu_acc ? lsu_addr_i : ifu_addr_i;
                r_info  <= w_lsu_acc ? lsu_info_i : 7'd0;
                r_wdata <= w_lsu_acc ? lsu_wdata_i : '0;
                r_owner <= {w_lsu_acc, w_ifu_acc};
                if (w_bad) begin
                    r_err      <= 1'b1;
                    r_lsu_resp <= w_lsu_acc;
                    r_ifu_resp <= w_ifu_acc;
                    if (w_lsu_acc) r_rdata <= '0;
                    else           r_inst  <= '0;
                end
            end
            if (w_done) begin
                r_lsu_resp <= r_owner[1];
                r_ifu_resp <= r_owner[0];
                if (r_owner[1]) r_rdata <= r_info[0] ? w_ext : '0;
                if (r_owner[0]) r_inst  <= r_addr[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
            end
        end
    end
    assign mem_req_valid_o  = (r_state == REQ);
    assign mem_addr_o       = {r_addr[ADDR_W-1:3], 3'b000};
    assign mem_wen_o        = r_info[1];
    assign mem_wdata_o      = r_wdata << {w_sh, 3'b000};
    assign mem_wmask_o      = !r_info[1] ? 8'h00
                            : r_info[6]  ? 8'hFF
                            : r_info[5]  ? 8'h0F << w_sh
                            : r_info[4]  ? 8'h03 << w_sh
                            : r_info[3]  ? 8'h01 << w_sh
                            :              8'h00;
    assign ifu_resp_valid_o = r_ifu_resp;
    assign ifu_inst_o       = r_inst;
    assign lsu_resp_valid_o = r_lsu_resp;
    assign lsu_rdata_o      = r_rdata;
    assign err_misalign_o   = r_err;
endmodule

// File: tb/tb_ysyx_22040237_mem_arb.sv
// tb_ysyx_22040237_mem_arb: directed scoreboard bench for the memory arbiter
module tb_ysyx_22040237_mem_arb;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ifu_req_valid_i = 0, ifu_req_ready_o, ifu_resp_valid_o;
    logic [63:0] ifu_addr_i = 0;
    logic [31:0] ifu_inst_o;
    logic        lsu_req_valid_i = 0, lsu_req_ready_o, lsu_resp_valid_o;
    logic [63:0] lsu_addr_i = 0, lsu_wdata_i = 0, lsu_rdata_o;
    logic [6:0]  lsu_info_i = 0;
    logic        mem_req_valid_o, mem_req_ready_i = 0, mem_wen_o, mem_rvalid_i = 0, err_misalign_o;
    logic [63:0] mem_addr_o, mem_wdata_o, mem_rdata_i = 0;
    logic [7:0]  mem_wmask_o;
    typedef struct packed {logic lsu; logic err; logic [63:0] data;} exp_t;
    exp_t q[$];
    int checks = 0, errors = 0, n;
    localparam logic [6:0] LD_B = 7'b0001001, LD_BU = 7'b0001101, LD_W = 7'b0100001,
                           LD_D = 7'b1000001, ST_H = 7'b0010010, LD_NOSZ = 7'b0000001;
    ysyx_22040237_mem_arb dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o), .ifu_addr_i(ifu_addr_i),
        .ifu_resp_valid_o(ifu_resp_valid_o), .ifu_inst_o(ifu_inst_o),
        .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o), .lsu_addr_i(lsu_addr_i),
        .lsu_info_i(lsu_info_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
        .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_misalign_o(err_misalign_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic issue_lsu(input logic [63:0] a, input logic [6:0] inf, input logic [63:0] wd);
        @(negedge clk);
        lsu_req_valid_i = 1; lsu_addr_i = a; lsu_info_i = inf; lsu_wdata_i = wd;
        #1 chk("lsu_ready", 64'(lsu_req_ready_o), 64'd1);
        @(posedge clk);
        #1 lsu_req_valid_i = 0;
    endtask
    task automatic issue_ifu(input logic [63:0] a);
        @(negedge clk);
        ifu_req_valid_i = 1; ifu_addr_i = a;
        #1 chk("ifu_ready", 64'(ifu_req_ready_o), 64'd1);
        @(posedge clk);
        #1 ifu_req_valid_i = 0;
    endtask
    task automatic wait_resp(input int max, output int cnt);
        exp_t e;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(ifu_resp_valid_o || lsu_resp_valid_o) && cnt < max);
        if (!(ifu_resp_valid_o || lsu_resp_valid_o)) begin
            checks++; errors++;
            $error("FAIL resp_timeout: no response within %0d cycles, one required", max);
        end else if (q.size() == 0) begin
            checks++; errors++;
            $error("FAIL scoreboard: response observed, none expected");
        end else begin
            e = q.pop_front();
            chk("resp_lsu", 64'(lsu_resp_valid_o), 64'(e.lsu));
            chk("resp_ifu", 64'(ifu_resp_valid_o), 64'(!e.lsu));
            chk("resp_data", e.lsu ? lsu_rdata_o : 64'(ifu_inst_o), e.data);
            chk("resp_err", 64'(err_misalign_o), 64'(e.err));
        end
    endtask
    task automatic pulse_end();
        @(negedge clk);
        chk("pulse_lsu", 64'(lsu_resp_valid_o), 64'd0);
        chk("pulse_ifu", 64'(ifu_resp_valid_o), 64'd0);
        chk("pulse_err", 64'(err_misalign_o), 64'd0);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_memv", 64'(mem_req_valid_o), 64'd0);
        chk("rst_addr", mem_addr_o, 64'd0);
        chk("rst_wmask", 64'(mem_wmask_o), 64'd0);
        chk("rst_wen", 64'(mem_wen_o), 64'd0);
        chk("rst_resp", 64'({ifu_resp_valid_o, lsu_resp_valid_o, err_misalign_o}), 64'd0);
        chk("rst_data", lsu_rdata_o | 64'(ifu_inst_o), 64'd0);
        rst = 0;
        mem_req_ready_i = 1; mem_rvalid_i = 1;
        // fetch at 0x8000_0004, no memory wait states
        mem_rdata_i = 64'h1111_2222_3333_4444;
        q.push_back('{lsu: 0, err: 0, data: 64'h1111_2222});
        issue_ifu(64'h8000_0004);
        @(negedge clk);
        chk("f_memv", 64'(mem_req_valid_o), 64'd1);
        chk("f_addr", mem_addr_o, 64'h8000_0000);
        chk("f_wen", 64'(mem_wen_o), 64'd0);
        chk("f_wmask", 64'(mem_wmask_o), 64'd0);
        wait_resp(6, n);
        chk("f_latency", 64'(n), 64'd2);
        pulse_end();
        // simultaneous requests: LSU wins, IFU taken during the LSU response pulse
        mem_rdata_i = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        lsu_req_valid_i = 1; lsu_addr_i = 64'h100; lsu_info_i = LD_D;
        ifu_req_valid_i = 1; ifu_addr_i = 64'h8000_0010;
        q.push_back('{lsu: 1, err: 0, data: 64'h0123_4567_89AB_CDEF});
        q.push_back('{lsu: 0, err: 0, data: 64'h89AB_CDEF});
        #1;
        chk("arb_lsu_ready", 64'(lsu_req_ready_o), 64'd1);
        chk("arb_ifu_ready", 64'(ifu_req_ready_o), 64'd0);
        @(posedge clk);
        #1 lsu_req_valid_i = 0;
        wait_resp(6, n);
        chk("arb_latency", 64'(n), 64'd3);
        chk("arb_ifu_during_pulse", 64'(ifu_req_ready_o), 64'd1);
        @(posedge clk);
        #1 ifu_req_valid_i = 0;
        pulse_end();
        wait_resp(6, n);
        pulse_end();
        // signed and unsigned byte loads from byte lane 3
        mem_rdata_i = 64'h1122_3344_8055_6677;
        q.push_back('{lsu: 1, err: 0, data: 64'hFFFF_FFFF_FFFF_FF80});
        issue_lsu(64'h1003, LD_B, 64'd0);
        wait_resp(6, n);
        chk("lb_latency", 64'(n), 64'd3);
        pulse_end();
        chk("lb_hold", lsu_rdata_o, 64'hFFFF_FFFF_FFFF_FF80);
        q.push_back('{lsu: 1, err: 0, data: 64'h80});
        issue_lsu(64'h1003, LD_BU, 64'd0);
        wait_resp(6, n);
        pulse_end();
        // store half at lane 6 with three cycles of memory back-pressure
        mem_req_ready_i = 0;
        q.push_back('{lsu: 1, err: 0, data: 64'd0});
        issue_lsu(64'h2006, ST_H, 64'hBEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sh_memv", 64'(mem_req_valid_o), 64'd1);
            chk("sh_addr", mem_addr_o, 64'h2000);
            chk("sh_wen", 64'(mem_wen_o), 64'd1);
            chk("sh_wmask", 64'(mem_wmask_o), 64'hC0);
            chk("sh_wdata", mem_wdata_o, 64'hBEEF_0000_0000_0000);
        end
        mem_req_ready_i = 1;
        wait_resp(6, n);
        pulse_end();
        // misaligned word load is rejected without touching memory
        q.push_back('{lsu: 1, err: 1, data: 64'd0});
        issue_lsu(64'h3002, LD_W, 64'd0);
        wait_resp(2, n);
        chk("mis_latency", 64'(n), 64'd1);
        chk("mis_memv", 64'(mem_req_valid_o), 64'd0);
        ifu_req_valid_i = 1; ifu_addr_i = 64'h8000_0000;
        #1 chk("mis_blocked", 64'(ifu_req_ready_o), 64'd0);
        ifu_req_valid_i = 0;
        pulse_end();
        // load with no size bit and misaligned fetch are also rejected
        q.push_back('{lsu: 1, err: 1, data: 64'd0});
        issue_lsu(64'h3000, LD_NOSZ, 64'd0);
        wait_resp(2, n);
        pulse_end();
        q.push_back('{lsu: 0, err: 1, data: 64'd0});
        issue_ifu(64'h8000_0002);
        wait_resp(2, n);
        chk("mis_ifu_memv", 64'(mem_req_valid_o), 64'd0);
        pulse_end();
        // reset while waiting for read data, then a stray rvalid
        mem_rvalid_i = 0;
        issue_lsu(64'h4000, LD_D, 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rr_in_resp", 64'(mem_req_valid_o), 64'd0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        mem_rvalid_i = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rr_no_resp", 64'({ifu_resp_valid_o, lsu_resp_valid_o}), 64'd0);
            chk("rr_memv", 64'(mem_req_valid_o), 64'd0);
        end
        ifu_req_valid_i = 1; ifu_addr_i = 64'h0;
        #1 chk("rr_idle", 64'(ifu_req_ready_o), 64'd1);
        ifu_req_valid_i = 0;
        chk("sb_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
